// File: rtl/obi_copy_pkg.sv
// Shared types for the OBI block-copy manager.
// State encoding and word/byte-enable constants.
package obi_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    FINISH
  } copy_state_e;

  localparam int unsigned WordBytes = 4;
  localparam logic [3:0]  FullBe    = 4'hF;

endpackage

// File: rtl/obi_bus.sv
// OBI request/response channel bundle.
// Manager drives the A-channel, subordinate answers on the R-channel.
interface OBI_BUS #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);

  logic                   req;
  logic                   gnt;
  logic [AddrWidth-1:0]   addr;
  logic                   we;
  logic [DataWidth/8-1:0] be;
  logic [DataWidth-1:0]   wdata;
  logic                   rvalid;
  logic [DataWidth-1:0]   rdata;
  logic                   err;

  modport Manager (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport Subordinate (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/obi_block_copy.sv
// OBI manager copying a block of words src -> dst.
// One outstanding transaction: read word, write word, repeat.
module obi_block_copy
  import obi_copy_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] src_addr_i,
  input  logic [AddrWidth-1:0] dst_addr_i,
  input  logic [CntWidth-1:0]  num_words_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  OBI_BUS.Manager              mgr
);

  if (DataWidth != 32) begin : g_dw_chk
    $error("obi_block_copy: DataWidth must be 32");
  end

  localparam logic [AddrWidth-1:0] Step =
    AddrWidth'(WordBytes);
  localparam logic [AddrWidth-1:0] LowMask =
    ~AddrWidth'(WordBytes - 1);

  copy_state_e          state_q, state_d;
  logic [AddrWidth-1:0] src_q, dst_q;
  logic [CntWidth-1:0]  cnt_q;
  logic [DataWidth-1:0] data_q;

  // State, operand, data and status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_o  <= (state_q != IDLE);
      done_o  <= (state_q == FINISH);
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            src_q <= src_addr_i & LowMask;
            dst_q <= dst_addr_i & LowMask;
            cnt_q <= num_words_i;
            err_o <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (mgr.rvalid) begin
            if (mgr.err) err_o  <= 1'b1;
            else         data_q <= mgr.rdata;
          end
        end
        WR_WAIT: begin
          if (mgr.rvalid) begin
            if (mgr.err) begin
              err_o <= 1'b1;
            end else begin
              src_q <= src_q + Step;
              dst_q <= dst_q + Step;
              cnt_q <= cnt_q - CntWidth'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and OBI request signals; idle bus is all-zero.
  always_comb begin
    state_d   = state_q;
    mgr.req   = 1'b0;
    mgr.we    = 1'b0;
    mgr.be    = '0;
    mgr.addr  = '0;
    mgr.wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (num_words_i == '0) ? FINISH
                                        : RD_REQ;
        end
      end
      RD_REQ: begin
        mgr.req  = 1'b1;
        mgr.be   = FullBe;
        mgr.addr = src_q;
        if (mgr.gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mgr.rvalid) begin
          state_d = mgr.err ? IDLE : WR_REQ;
        end
      end
      WR_REQ: begin
        mgr.req   = 1'b1;
        mgr.we    = 1'b1;
        mgr.be    = FullBe;
        mgr.addr  = dst_q;
        mgr.wdata = data_q;
        if (mgr.gnt) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (mgr.rvalid) begin
          if (mgr.err)                     state_d = IDLE;
          else if (cnt_q == CntWidth'(1)) state_d = FINISH;
          else                             state_d = RD_REQ;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_obi_block_copy.sv
// Directed bench for obi_block_copy with an OBI SRAM
// subordinate model (zero-wait or random-stall).
module tb_obi_block_copy;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] num_words = '0;
  logic        busy_o, done_o, err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  OBI_BUS #(.AddrWidth(32), .DataWidth(32)) bus ();

  obi_block_copy #(
    .AddrWidth(32), .DataWidth(32), .CntWidth(16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .src_addr_i (src_addr),
    .dst_addr_i (dst_addr),
    .num_words_i(num_words),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .mgr        (bus)
  );

  // Unwritten memory reads back a fixed address pattern.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a < 32'h100) return 32'hA0 + {26'd0, a[7:2]};
    return 32'h5A00_0000 ^ a;
  endfunction

  // ---------------- subordinate model ----------------
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wr_addr_q [$];
  logic [31:0] rd_addr_q [$];
  bit          stall = 1'b0;
  int          err_rd = 0;
  int          rd_total = 0;
  int          gnt_wait = 0;
  int          gnt_dly = 0;
  int          rv_left = 0;
  logic        pend = 1'b0;
  logic        pend_we = 1'b0;
  logic [31:0] pend_rdata = '0;

  assign bus.gnt    = bus.req && (gnt_wait >= gnt_dly);
  assign bus.rvalid = pend && (rv_left == 0);
  assign bus.rdata  = pend_rdata;
  assign bus.err    = bus.rvalid && !pend_we &&
                      (rd_total + 1 == err_rd);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= 1'b0;
      rv_left  <= 0;
      gnt_wait <= 0;
      gnt_dly  <= 0;
    end else begin
      if (pend) begin
        if (rv_left == 0) begin
          pend <= 1'b0;
          if (!pend_we) rd_total <= rd_total + 1;
        end else begin
          rv_left <= rv_left - 1;
        end
      end
      if (bus.req && bus.gnt) begin
        pend     <= 1'b1;
        pend_we  <= bus.we;
        gnt_wait <= 0;
        gnt_dly  <= stall ? int'($urandom_range(0, 5)) : 0;
        rv_left  <= stall ? int'($urandom_range(0, 4)) : 0;
        if (bus.we) begin
          mem[bus.addr] = bus.wdata;
          wr_addr_q.push_back(bus.addr);
        end else begin
          pend_rdata <= mem.exists(bus.addr) ?
                        mem[bus.addr] : init_word(bus.addr);
          rd_addr_q.push_back(bus.addr);
        end
      end else if (bus.req) begin
        gnt_wait <= gnt_wait + 1;
      end
    end
  end

  // Request must hold steady until granted.
  logic        p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [3:0]  p_be = '0;
  int          stab_samples = 0;
  int          stab_viol = 0;

  always @(negedge clk) begin
    if (rst) begin
      p_req <= 1'b0;
    end else begin
      if (p_req && !p_gnt) begin
        stab_samples <= stab_samples + 1;
        if (!bus.req || bus.addr != p_addr ||
            bus.we != p_we || bus.wdata != p_wdata ||
            bus.be != p_be)
          stab_viol <= stab_viol + 1;
      end
      p_req   <= bus.req;
      p_gnt   <= bus.gnt;
      p_addr  <= bus.addr;
      p_we    <= bus.we;
      p_wdata <= bus.wdata;
      p_be    <= bus.be;
    end
  end

  // ---------------- helpers ----------------
  // Cycle counts are edges after the edge that accepts start.
  task automatic run_copy(
    input  logic [31:0] src, dst,
    input  logic [15:0] n,
    input  int          budget,
    output int          done_cyc,
    output int          busy_cyc,
    output int          done_cnt,
    output int          req_cyc,
    output bit          tmo
  );
    int cyc;
    @(posedge clk); #1;
    src_addr = src; dst_addr = dst; num_words = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; done_cyc = -1; busy_cyc = 0; done_cnt = 0;
    req_cyc = bus.req ? 1 : 0;
    tmo = 1'b1;
    while (cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.req) req_cyc++;
      if (busy_o) busy_cyc++;
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc >= 2 && !busy_o) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #3 rst = 1'b1;
    #2;
    checks++;
    if (bus.req !== 1'b0 || bus.we !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_we: got %b%b want 00",
               bus.req, bus.we);
    end
    checks++;
    if (bus.be !== 4'h0 || bus.addr !== 32'h0 ||
        bus.wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: be=%h addr=%h wdata=%h want 0",
               bus.be, bus.addr, bus.wdata);
    end
    checks++;
    if ({busy_o, done_o, err_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got %b want 000",
               {busy_o, done_o, err_o});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic;
    int dc, bc, dn, rq, base;
    bit to;
    base = wr_addr_q.size();
    run_copy(32'h0, 32'h100, 16'd4, 200, dc, bc, dn, rq, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL basic_timeout: got busy want idle");
    end
    checks++;
    if (dc !== 17) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d want 17", dc);
    end
    checks++;
    if (bc !== 17) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d want 17", bc);
    end
    checks++;
    if (dn !== 1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_err: got %0d/%b want 1/0",
               dn, err_o);
    end
    checks++;
    if (wr_addr_q.size() - base !== 4) begin
      errors++;
      $display("FAIL basic_writes: got %0d want 4",
               wr_addr_q.size() - base);
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, w;
      a = 32'h100 + 32'(4 * i);
      w = mem.exists(a) ? mem[a] : 32'hX;
      checks++;
      if (w !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL basic_data[%0d]: got %h want %h",
                 i, w, 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_zero_len;
    int dc, bc, dn, rq;
    bit to;
    run_copy(32'h40, 32'h140, 16'd0, 50, dc, bc, dn, rq, to);
    checks++;
    if (to || rq !== 0) begin
      errors++;
      $display("FAIL zero_req: got %0d req cycles want 0", rq);
    end
    checks++;
    if (dc !== 1 || dn !== 1) begin
      errors++;
      $display("FAIL zero_done: got cyc %0d cnt %0d want 1/1",
               dc, dn);
    end
    checks++;
    if (bc !== 1) begin
      errors++;
      $display("FAIL zero_busy: got %0d want 1", bc);
    end
  endtask

  task automatic test_stall;
    int dc, bc, dn, rq;
    bit to;
    stall = 1'b1;
    run_copy(32'h200, 32'h400, 16'd16, 2000,
             dc, bc, dn, rq, to);
    stall = 1'b0;
    checks++;
    if (to || dn !== 1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: got to=%b done=%0d err=%b want 0/1/0",
               to, dn, err_o);
    end
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, w, e;
      a = 32'h400 + 32'(4 * i);
      e = 32'h5A00_0000 ^ (32'h200 + 32'(4 * i));
      w = mem.exists(a) ? mem[a] : 32'hX;
      checks++;
      if (w !== e) begin
        errors++;
        $display("FAIL stall_data[%0d]: got %h want %h", i, w, e);
      end
    end
    checks++;
    if (stab_samples == 0 || stab_viol !== 0) begin
      errors++;
      $display("FAIL stall_stable: got %0d viol in %0d want 0 in >0",
               stab_viol, stab_samples);
    end
  endtask

  task automatic test_err;
    int dc, bc, dn, rq, base;
    bit to;
    base = wr_addr_q.size();
    err_rd = rd_total + 3;
    run_copy(32'h600, 32'h700, 16'd8, 500, dc, bc, dn, rq, to);
    err_rd = 0;
    checks++;
    if (to || wr_addr_q.size() - base !== 2) begin
      errors++;
      $display("FAIL err_writes: got %0d want 2",
               wr_addr_q.size() - base);
    end
    checks++;
    if (mem[32'h704] !== 32'h5A00_0604) begin
      errors++;
      $display("FAIL err_word2: got %h want 5a000604",
               mem[32'h704]);
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL err_no_done: got %0d want 0", dn);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky: got err=%b busy=%b want 1/0",
               err_o, busy_o);
    end
    run_copy(32'h600, 32'h780, 16'd1, 100, dc, bc, dn, rq, to);
    checks++;
    if (to || err_o !== 1'b0 || dn !== 1) begin
      errors++;
      $display("FAIL err_clear: got err=%b done=%0d want 0/1",
               err_o, dn);
    end
  endtask

  task automatic test_wrap;
    int dc, bc, dn, rq, base;
    bit to;
    base = rd_addr_q.size();
    run_copy(32'hFFFF_FFF8, 32'h800, 16'd3, 200,
             dc, bc, dn, rq, to);
    checks++;
    if (to || rd_addr_q.size() - base !== 3) begin
      errors++;
      $display("FAIL wrap_reads: got %0d want 3",
               rd_addr_q.size() - base);
    end else begin
      logic [31:0] exp_a [3];
      exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rd_addr_q[base + i] !== exp_a[i]) begin
          errors++;
          $display("FAIL wrap_addr[%0d]: got %h want %h",
                   i, rd_addr_q[base + i], exp_a[i]);
        end
      end
    end
    checks++;
    if (mem[32'h808] !== 32'hA0) begin
      errors++;
      $display("FAIL wrap_data: got %h want 000000a0",
               mem[32'h808]);
    end
  endtask

  task automatic test_reset_midcopy;
    int  base, cyc, dn;
    bit  found;
    base = wr_addr_q.size();
    @(posedge clk); #1;
    src_addr = 32'h0; dst_addr = 32'h900; num_words = 16'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req && bus.we) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrst_wrreq: got no write req want one");
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.req !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drop: got req=%b busy=%b want 0/0",
               bus.req, busy_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (wr_addr_q.size() !== base) begin
      errors++;
      $display("FAIL midrst_nowrite: got %0d want 0",
               wr_addr_q.size() - base);
    end
    @(posedge clk); #1;
    src_addr = 32'h00C; dst_addr = 32'hA00; num_words = 16'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src_addr = 32'h40; dst_addr = 32'hB00; num_words = 16'd5;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; dn = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done_o) dn++;
      if (!busy_o) break;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cyc >= 100 || dn !== 1) begin
      errors++;
      $display("FAIL midrst_done: got %0d want 1", dn);
    end
    checks++;
    if (wr_addr_q.size() - base !== 1 ||
        wr_addr_q[wr_addr_q.size() - 1] !== 32'hA00) begin
      errors++;
      $display("FAIL midrst_ignore: got %0d writes want 1 at a00",
               wr_addr_q.size() - base);
    end
    checks++;
    if (mem[32'hA00] !== 32'hA3) begin
      errors++;
      $display("FAIL midrst_data: got %h want 000000a3",
               mem[32'hA00]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_stall();
    test_err();
    test_wrap();
    test_reset_midcopy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
